execute_stage_mdu: RTL and testbench



---
 rtl/execute_stage_mdu_pkg.sv | 46 ++++
 rtl/execute_stage_mdu_mdu_iterative.sv | 147 ++++++++++++++
 rtl/execute_stage_mdu.sv | 180 ++++++++++++++++++
 tb/tb_execute_stage_mdu.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_stage_mdu_pkg.sv
// Shared types and op classification for the execute stage and its iterative multiply/divide unit.
package execute_stage_mdu_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_AND    = 5'd2,
        OP_OR     = 5'd3,
        OP_XOR    = 5'd4,
        OP_SLL    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_SLT    = 5'd8,
        OP_SLTU   = 5'd9,
        OP_MUL    = 5'd16,
        OP_MULH   = 5'd17,
        OP_MULHSU = 5'd18,
        OP_MULHU  = 5'd19,
        OP_DIV    = 5'd20,
        OP_DIVU   = 5'd21,
        OP_REM    = 5'd22,
        OP_REMU   = 5'd23
    } ex_op_t;

    typedef enum logic [1:0] {FWD_NONE, FWD_EX_MEM, FWD_MEM_WB} fwd_sel_t;

    typedef enum logic [1:0] {IDLE, RUN, FIX} mdu_state_t;

    function automatic logic is_mdu_op(ex_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                          OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_div_op(ex_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic op_a_signed(ex_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_b_signed(ex_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/execute_stage_mdu_mdu_iterative.sv
// Radix-2 iterative multiply/divide: magnitudes are processed for XLEN cycles, then the sign
// fix-up and high/low selection happen in a final cycle that waits for the result register.
module mdu_iterative
    import execute_stage_mdu_pkg::*;
#(
    parameter int unsigned XLEN                   = 32,
    parameter bit          DIV_ZERO_QUOT_ALL_ONES = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            start,
    input  ex_op_t          op,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    input  logic            res_ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned   CW   = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    mdu_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    ex_op_t          op_q, op_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic            neg_q, neg_d, dz_q, dz_d;

    logic              a_sgn, b_sgn;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic [XLEN:0]     sum, shifted, diff;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix;

    always_comb begin
        a_sgn   = op_a_signed(op) && opa[XLEN-1];
        b_sgn   = op_b_signed(op) && opb[XLEN-1];
        a_abs   = a_sgn ? -opa : opa;
        b_abs   = b_sgn ? -opb : opb;
        // hi:lo is the accumulator:multiplier pair or the remainder:quotient pair
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, b_q};
    end

    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = neg_q ? -prod : prod;
        rem_fix  = neg_q ? -hi_q : hi_q;
        if (dz_q) begin
            quot_fix = DIV_ZERO_QUOT_ALL_ONES ? '1 : '0;
        end else begin
            quot_fix = neg_q ? -lo_q : lo_q;
        end
        case (op_q)
            OP_MUL:                      result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             result = quot_fix;
            default:                     result = rem_fix;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        neg_d   = neg_q;
        dz_d    = dz_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    op_d    = op;
                    hi_d    = '0;
                    lo_d    = a_abs;
                    b_d     = b_abs;
                    // Remainder takes the dividend's sign; everything else the XOR of signs
                    neg_d   = (op == OP_REM) ? a_sgn : (a_sgn ^ b_sgn);
                    dz_d    = (opb == '0);
                end
            end
            RUN: begin
                if (is_div_op(op_q)) begin
                    if (!diff[XLEN]) begin
                        hi_d = diff[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_d = shifted[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    hi_d = sum[XLEN:1];
                    lo_d = {sum[0], lo_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = FIX;
                    cnt_d   = '0;
                end
            end
            FIX: begin
                if (res_ready) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            done    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MUL;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            dz_q    <= dz_d;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: rtl/execute_stage_mdu.sv
// Execute stage: operand forwarding, single-cycle ALU and an iterative MDU feeding a registered
// EX/MEM output behind a valid/ready handshake.
module execute_stage_mdu
    import execute_stage_mdu_pkg::*;
#(
    parameter int unsigned XLEN                   = 32,
    parameter int unsigned REG_AW                 = 5,
    parameter bit          DIV_ZERO_QUOT_ALL_ONES = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  ex_op_t            op,
    input  logic              alu_src,
    input  logic [XLEN-1:0]   data1,
    input  logic [XLEN-1:0]   data2,
    input  logic [XLEN-1:0]   imm,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd_in,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic              ex_mem_reg_write,
    input  logic              mem_wb_reg_write,
    input  logic [XLEN-1:0]   forward_ex_mem,
    input  logic [XLEN-1:0]   forward_mem_wb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result,
    output logic [XLEN-1:0]   store_data,
    output logic [REG_AW-1:0] rd_out,
    output logic              zero_flag,
    output logic              busy
);

    localparam int unsigned SHW = $clog2(XLEN);

    fwd_sel_t        sel1, sel2;
    logic [XLEN-1:0] fwd1, fwd2, rhs, alu_res, mdu_res;
    logic [SHW-1:0]  shamt;
    logic            mdu_busy, mdu_done, out_free, accept, mdu_start;

    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   result_q, result_d, store_data_q, store_data_d;
    logic [REG_AW-1:0] rd_q, rd_d, mdu_rd_q, mdu_rd_d;
    logic [XLEN-1:0]   mdu_sd_q, mdu_sd_d;
    logic              zero_q, zero_d;

    // EX/MEM is the younger producer, so it takes priority over MEM/WB
    always_comb begin
        sel1 = FWD_NONE;
        if (ex_mem_reg_write && ex_mem_rd == rs1 && rs1 != '0) begin
            sel1 = FWD_EX_MEM;
        end else if (mem_wb_reg_write && mem_wb_rd == rs1 && rs1 != '0) begin
            sel1 = FWD_MEM_WB;
        end
        sel2 = FWD_NONE;
        if (ex_mem_reg_write && ex_mem_rd == rs2 && rs2 != '0) begin
            sel2 = FWD_EX_MEM;
        end else if (mem_wb_reg_write && mem_wb_rd == rs2 && rs2 != '0) begin
            sel2 = FWD_MEM_WB;
        end
    end

    always_comb begin
        unique case (sel1)
            FWD_EX_MEM: fwd1 = forward_ex_mem;
            FWD_MEM_WB: fwd1 = forward_mem_wb;
            default:    fwd1 = data1;
        endcase
        unique case (sel2)
            FWD_EX_MEM: fwd2 = forward_ex_mem;
            FWD_MEM_WB: fwd2 = forward_mem_wb;
            default:    fwd2 = data2;
        endcase
        rhs = alu_src ? imm : fwd2;
    end

    always_comb begin
        shamt = rhs[SHW-1:0];
        case (op)
            OP_ADD:  alu_res = fwd1 + rhs;
            OP_SUB:  alu_res = fwd1 - rhs;
            OP_AND:  alu_res = fwd1 & rhs;
            OP_OR:   alu_res = fwd1 | rhs;
            OP_XOR:  alu_res = fwd1 ^ rhs;
            OP_SLL:  alu_res = fwd1 << shamt;
            OP_SRL:  alu_res = fwd1 >> shamt;
            OP_SRA:  alu_res = $signed(fwd1) >>> shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(fwd1) < $signed(rhs)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, fwd1 < rhs};
            default: alu_res = '0;
        endcase
    end

    assign out_free  = !out_valid_q || out_ready;
    assign in_ready  = !mdu_busy && out_free;
    assign accept    = in_valid && in_ready && !flush;
    assign mdu_start = accept && is_mdu_op(op);

    mdu_iterative #(
        .XLEN                   (XLEN),
        .DIV_ZERO_QUOT_ALL_ONES (DIV_ZERO_QUOT_ALL_ONES)
    ) u_mdu (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .start     (mdu_start),
        .op        (op),
        .opa       (fwd1),
        .opb       (rhs),
        .res_ready (out_free),
        .busy      (mdu_busy),
        .done      (mdu_done),
        .result    (mdu_res)
    );

    always_comb begin
        out_valid_d  = out_valid_q;
        result_d     = result_q;
        store_data_d = store_data_q;
        rd_d         = rd_q;
        zero_d       = zero_q;
        mdu_rd_d     = mdu_rd_q;
        mdu_sd_d     = mdu_sd_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (mdu_start) begin
            mdu_rd_d = rd_in;
            mdu_sd_d = fwd2;
        end
        if (mdu_done) begin
            out_valid_d  = 1'b1;
            result_d     = mdu_res;
            store_data_d = mdu_sd_q;
            rd_d         = mdu_rd_q;
            zero_d       = (mdu_res == '0);
        end else if (accept && !is_mdu_op(op)) begin
            out_valid_d  = 1'b1;
            result_d     = alu_res;
            store_data_d = fwd2;
            rd_d         = rd_in;
            zero_d       = (alu_res == '0);
        end
        if (flush) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            result_q     <= '0;
            store_data_q <= '0;
            rd_q         <= '0;
            zero_q       <= 1'b0;
            mdu_rd_q     <= '0;
            mdu_sd_q     <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            result_q     <= result_d;
            store_data_q <= store_data_d;
            rd_q         <= rd_d;
            zero_q       <= zero_d;
            mdu_rd_q     <= mdu_rd_d;
            mdu_sd_q     <= mdu_sd_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign store_data = store_data_q;
    assign rd_out     = rd_q;
    assign zero_flag  = zero_q;
    assign busy       = mdu_busy;

endmodule

// File: tb/tb_execute_stage_mdu.sv
// Scoreboard bench for execute_stage_mdu: a driver pushes reference results at accept time,
// a monitor compares whatever the output register presents against the queue head.
module tb_execute_stage_mdu;
    import execute_stage_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    ex_op_t      op = OP_ADD;
    logic        alu_src = 1'b0;
    logic [31:0] data1 = '0, data2 = '0, imm = '0;
    logic [4:0]  rs1 = '0, rs2 = '0, rd_in = '0, ex_mem_rd = '0, mem_wb_rd = '0;
    logic        ex_mem_reg_write = 1'b0, mem_wb_reg_write = 1'b0;
    logic [31:0] forward_ex_mem = '0, forward_mem_wb = '0;
    logic        out_valid, out_ready;
    logic [31:0] result, store_data;
    logic [4:0]  rd_out;
    logic        zero_flag, busy;

    logic rand_rdy = 1'b0, rnd_rdy = 1'b1, dir_rdy = 1'b1;
    assign out_ready = rand_rdy ? rnd_rdy : dir_rdy;

    typedef struct {
        logic [31:0] res;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        z;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    bit   shown = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    execute_stage_mdu dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .op               (op),
        .alu_src          (alu_src),
        .data1            (data1),
        .data2            (data2),
        .imm              (imm),
        .rs1              (rs1),
        .rs2              (rs2),
        .rd_in            (rd_in),
        .ex_mem_rd        (ex_mem_rd),
        .mem_wb_rd        (mem_wb_rd),
        .ex_mem_reg_write (ex_mem_reg_write),
        .mem_wb_reg_write (mem_wb_reg_write),
        .forward_ex_mem   (forward_ex_mem),
        .forward_mem_wb   (forward_mem_wb),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .result           (result),
        .store_data       (store_data),
        .rd_out           (rd_out),
        .zero_flag        (zero_flag),
        .busy             (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1;
        rnd_rdy = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: RV32 semantics with plain 64-bit arithmetic
    function automatic logic [31:0] ref_op(ex_op_t o, logic [31:0] a, logic [31:0] b);
        longint            sa = longint'($signed(a));
        longint            sb = longint'($signed(b));
        longint unsigned   ua = 64'(a);
        longint unsigned   ub = 64'(b);
        logic [63:0]       p;
        logic [4:0]        sh;
        sh = b[4:0];
        case (o)
            OP_ADD:    return a + b;
            OP_SUB:    return a - b;
            OP_AND:    return a & b;
            OP_OR:     return a | b;
            OP_XOR:    return a ^ b;
            OP_SLL:    return a << sh;
            OP_SRL:    return a >> sh;
            OP_SRA:    return $signed(a) >>> sh;
            OP_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU:   return (a < b) ? 32'd1 : 32'd0;
            OP_MUL:    begin p = 64'(sa * sb); return p[31:0]; end
            OP_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
            OP_MULHSU: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
            OP_MULHU:  begin p = ua * ub; return p[63:32]; end
            OP_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = 64'(sa / sb);
                return p[31:0];
            end
            OP_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            OP_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = 64'(sa % sb);
                return p[31:0];
            end
            default:   return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] fwd(logic [4:0] rs, logic [31:0] rf);
        if (ex_mem_reg_write && ex_mem_rd == rs && rs != 5'd0) return forward_ex_mem;
        if (mem_wb_reg_write && mem_wb_rd == rs && rs != 5'd0) return forward_mem_wb;
        return rf;
    endfunction

    function automatic bit mdu_op(ex_op_t o);
        return o inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic set_stim(input ex_op_t o, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
        op = o;
        data1 = a;
        data2 = b;
        imm = $urandom();
        alu_src = 1'b0;
        rs1 = 5'd0;
        rs2 = 5'd0;
        rd_in = rd;
        ex_mem_reg_write = 1'b0;
        mem_wb_reg_write = 1'b0;
    endtask

    // Holds in_valid until accepted; waits = extra cycles spent before acceptance
    task automatic send(input bit push, output int waits);
        exp_t        e;
        logic [31:0] a, b2, rhs;
        waits = 0;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 200) begin
                chk("accept_timeout", 32'(waits), 32'd0);
                in_valid = 1'b0;
                return;
            end
        end
        a = fwd(rs1, data1);
        b2 = fwd(rs2, data2);
        rhs = alu_src ? imm : b2;
        e.res = ref_op(op, a, rhs);
        e.sd = b2;
        e.rd = rd_in;
        e.z = (e.res == 32'd0);
        e.lat = mdu_op(op) ? 34 : 1;
        e.acc = cyc;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        sync();
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                mon_e = exp_q[0];
                if (!shown) begin
                    chk("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
                    shown = 1'b1;
                end
                chk("result", result, mon_e.res);
                chk("store_data", store_data, mon_e.sd);
                chk("rd_out", 32'(rd_out), 32'(mon_e.rd));
                chk("zero_flag", 32'(zero_flag), 32'(mon_e.z));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    shown = 1'b0;
                end
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_result"}, result, 32'd0);
        chk({tag, "_store_data"}, store_data, 32'd0);
        chk({tag, "_rd_out"}, 32'(rd_out), 32'd0);
        chk({tag, "_zero_flag"}, 32'(zero_flag), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    ex_op_t all_ops[18] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
                            OP_SLT, OP_SLTU, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                            OP_DIV, OP_DIVU, OP_REM, OP_REMU};

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 40));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int w;
        int cnt;

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        sync();

        // Basic ADD and a zero result
        set_stim(OP_ADD, 32'd5, 32'd7, 5'd4);
        send(1'b1, w);
        set_stim(OP_SUB, 32'd9, 32'd9, 5'd6);
        send(1'b1, w);
        drain();

        // Forwarding priority: EX/MEM over MEM/WB for rs1; rs2=x0 never forwards
        set_stim(OP_ADD, 32'd99, 32'd1, 5'd7);
        rs1 = 5'd3;
        ex_mem_rd = 5'd3; ex_mem_reg_write = 1'b1; forward_ex_mem = 32'h10;
        mem_wb_rd = 5'd3; mem_wb_reg_write = 1'b1; forward_mem_wb = 32'h20;
        send(1'b1, w);
        set_stim(OP_ADD, 32'd2, 32'd1, 5'd8);
        rs2 = 5'd0; mem_wb_rd = 5'd0; mem_wb_reg_write = 1'b1; forward_mem_wb = 32'h55;
        send(1'b1, w);
        drain();

        // MULHU: in_ready low and busy high for the whole iteration
        set_stim(OP_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd9);
        send(1'b1, w);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
            chk("mdu_in_ready", 32'(in_ready), 32'd0);
        end
        chk("mdu_busy_cycles", 32'(cnt), 32'd33);
        drain();

        // Divide corner cases
        set_stim(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10); send(1'b1, w);
        set_stim(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11); send(1'b1, w);
        set_stim(OP_DIVU, 32'd7, 32'd0, 5'd12);                send(1'b1, w);
        set_stim(OP_REMU, 32'd7, 32'd0, 5'd13);                send(1'b1, w);
        set_stim(OP_DIV, 32'hFFFF_FFF9, 32'd0, 5'd14);         send(1'b1, w);
        set_stim(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd15);         send(1'b1, w);
        drain();

        // Backpressure: held output, blocked input, accept as soon as ready rises
        dir_rdy = 1'b0;
        set_stim(OP_XOR, 32'hA5A5_0000, 32'h0F0F_00FF, 5'd17);
        send(1'b1, w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        sync();
        dir_rdy = 1'b1;
        set_stim(OP_SLT, 32'hFFFF_FFFE, 32'd3, 5'd18);
        send(1'b1, w);
        chk("bp_accept_wait", 32'(w), 32'd0);
        drain();

        // Flush mid-RUN of a DIV
        set_stim(OP_DIV, 32'd1000, 32'd7, 5'd19);
        send(1'b0, w);
        repeat (10) @(posedge clk);
        #1;
        chk("div_running", 32'(busy), 32'd1);
        flush = 1'b1;
        sync();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_busy", 32'(busy), 32'd0);
        sync();
        set_stim(OP_ADD, 32'd40, 32'd2, 5'd20);
        send(1'b1, w);
        drain();

        // Flush in the accept cycle drops the op
        set_stim(OP_OR, 32'd1, 32'd2, 5'd21);
        flush = 1'b1;
        send(1'b0, w);
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush_accept_drop", 32'(out_valid), 32'd0);
        end
        sync();

        // Reset mid-RUN
        set_stim(OP_MUL, 32'd12345, 32'd678, 5'd22);
        send(1'b0, w);
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        sync();
        set_stim(OP_SRA, 32'h8000_0010, 32'd36, 5'd23);
        send(1'b1, w);
        drain();

        // Randomised traffic with random backpressure and forwarding
        rand_rdy = 1'b1;
        for (int n = 0; n < 160; n++) begin
            set_stim(all_ops[$urandom_range(0, 17)], rnd_val(), rnd_val(), 5'($urandom()));
            imm = rnd_val();
            alu_src = ($urandom_range(0, 3) == 0);
            rs1 = 5'($urandom_range(0, 3));
            rs2 = 5'($urandom_range(0, 3));
            ex_mem_rd = 5'($urandom_range(0, 3));
            mem_wb_rd = 5'($urandom_range(0, 3));
            ex_mem_reg_write = 1'($urandom_range(0, 1));
            mem_wb_reg_write = 1'($urandom_range(0, 1));
            forward_ex_mem = rnd_val();
            forward_mem_wb = rnd_val();
            send(1'b1, w);
            if ($urandom_range(0, 3) == 0) sync();
        end
        rand_rdy = 1'b0;
        dir_rdy = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
